// File: rtl/uop_pkg.sv
// Shared constants and state encoding for the uop replay sequencer.
package uop_pkg;

    localparam int UOP_ADDR_W = 9;
    localparam int UOP_DATA_W = 32;
    localparam int UOP_REP_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        REPLAY = 2'd2,
        DRAIN  = 2'd3
    } uop_state_e;

endpackage

// File: rtl/uop_cache.sv
// 512x32 simple dual-port uop store; registered read, output holds when not reading.
module uop_cache #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] instruction,
    input  logic              read_enable,
    input  logic [ADDR_W-1:0] read_address,
    output logic [DATA_W-1:0] out_instruction
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_address] <= instruction;
        end
        if (read_enable) begin
            out_instruction <= mem[read_address];
        end
    end

endmodule

// File: rtl/uop_skid_buf.sv
// Two-entry FIFO that absorbs the cache read latency; flush beats push/pop.
module uop_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [1:0]        count_o,
    output logic [DATA_W-1:0] head_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              rd_q;
    logic              wr_q;
    logic [1:0]        count_q;
    logic              pop_ok;

    assign pop_ok  = pop_i & (count_q != 2'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_ok) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/uop_replay_ctrl.sv
// Loads a uop program into the cache from the fill stream, then replays it
// cfg_repeat+1 times onto the output stream at up to one uop per cycle.
//
// state  | meaning
// IDLE   | waiting for cfg_start
// FILL   | accepting cfg_len uops, writing them from cfg_base upward
// REPLAY | issuing cache reads in address order, pass by pass
// DRAIN  | all reads issued; emptying skid buffer, then pulse done
module uop_replay_ctrl
    import uop_pkg::*;
#(
    parameter int ADDR_W = UOP_ADDR_W,
    parameter int DATA_W = UOP_DATA_W,
    parameter int REP_W  = UOP_REP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_len,
    input  logic [REP_W-1:0]  cfg_repeat,
    input  logic              abort,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [DATA_W-1:0] fill_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cache_write_enable,
    output logic [ADDR_W-1:0] cache_write_address,
    output logic [DATA_W-1:0] cache_instruction,
    output logic              cache_read_enable,
    output logic [ADDR_W-1:0] cache_read_address,
    input  logic [DATA_W-1:0] cache_out_instruction
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    uop_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d, len_q, len_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, rd_cnt_q, rd_cnt_d;
    logic [REP_W-1:0]  rep_q, rep_d, pass_q, pass_d;
    logic              inflight_q, inflight_d;
    logic              err_q, err_d, done_q, done_d;

    logic [1:0]        skid_count;
    logic              skid_pop;
    logic [2:0]        occupancy;

    // Slots already committed once this cycle's pop and in-flight read settle.
    assign skid_pop  = out_valid & out_ready;
    assign occupancy = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, skid_pop};

    assign out_valid = (skid_count != 2'd0);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

    uop_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush_i (abort),
        .push_i  (inflight_q),
        .data_i  (cache_out_instruction),
        .pop_i   (skid_pop),
        .count_o (skid_count),
        .head_o  (out_instr)
    );

    always_comb begin
        state_d             = state_q;
        base_d              = base_q;
        len_d               = len_q;
        rep_d               = rep_q;
        wr_ptr_d            = wr_ptr_q;
        wr_cnt_d            = wr_cnt_q;
        rd_ptr_d            = rd_ptr_q;
        rd_cnt_d            = rd_cnt_q;
        pass_d              = pass_q;
        inflight_d          = 1'b0;
        err_d               = err_q;
        done_d              = 1'b0;
        fill_ready          = 1'b0;
        cache_write_enable  = 1'b0;
        cache_write_address = wr_ptr_q;
        cache_instruction   = '0;
        cache_read_enable   = 1'b0;
        cache_read_address  = rd_ptr_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_start) begin
                        if (cfg_len == '0) begin
                            err_d = 1'b1;
                        end else begin
                            err_d    = 1'b0;
                            base_d   = cfg_base;
                            len_d    = cfg_len;
                            rep_d    = cfg_repeat;
                            wr_ptr_d = cfg_base;
                            wr_cnt_d = '0;
                            state_d  = FILL;
                        end
                    end
                end
                FILL: begin
                    fill_ready = 1'b1;
                    if (fill_valid) begin
                        cache_write_enable = 1'b1;
                        cache_instruction  = fill_instr;
                        wr_ptr_d           = wr_ptr_q + ONE;
                        wr_cnt_d           = wr_cnt_q + ONE;
                        if (wr_cnt_q == len_q - ONE) begin
                            rd_ptr_d = base_q;
                            rd_cnt_d = '0;
                            pass_d   = '0;
                            state_d  = REPLAY;
                        end
                    end
                end
                REPLAY: begin
                    if (occupancy < 3'd2) begin
                        cache_read_enable = 1'b1;
                        inflight_d        = 1'b1;
                        if (rd_cnt_q == len_q - ONE) begin
                            rd_ptr_d = base_q;
                            rd_cnt_d = '0;
                            if (pass_q == rep_q) begin
                                state_d = DRAIN;
                            end else begin
                                pass_d = pass_q + 1'b1;
                            end
                        end else begin
                            rd_ptr_d = rd_ptr_q + ONE;
                            rd_cnt_d = rd_cnt_q + ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (skid_count == 2'd0 && !inflight_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (cfg_start && state_q != IDLE) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            rep_q      <= '0;
            wr_ptr_q   <= '0;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            rd_cnt_q   <= '0;
            pass_q     <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            rep_q      <= rep_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_cnt_q   <= rd_cnt_d;
            pass_q     <= pass_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uop_replay_ctrl.sv
// Scoreboard bench for uop_replay_ctrl driving a real uop_cache.
module tb_uop_replay_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [AW-1:0] cfg_len = '0;
    logic [RW-1:0] cfg_repeat = '0;
    logic          abort = 1'b0;
    logic          fill_valid = 1'b0;
    logic          fill_ready;
    logic [DW-1:0] fill_instr = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_instr;
    logic          busy, done, err;
    logic          c_we, c_re;
    logic [AW-1:0] c_wa, c_ra;
    logic [DW-1:0] c_wd, c_rd;

    int tests = 0;
    int fails = 0;
    int n_out = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    uop_replay_ctrl u_dut (
        .clk                   (clk),
        .reset                 (reset),
        .cfg_start             (cfg_start),
        .cfg_base              (cfg_base),
        .cfg_len               (cfg_len),
        .cfg_repeat            (cfg_repeat),
        .abort                 (abort),
        .fill_valid            (fill_valid),
        .fill_ready            (fill_ready),
        .fill_instr            (fill_instr),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_instr             (out_instr),
        .busy                  (busy),
        .done                  (done),
        .err                   (err),
        .cache_write_enable    (c_we),
        .cache_write_address   (c_wa),
        .cache_instruction     (c_wd),
        .cache_read_enable     (c_re),
        .cache_read_address    (c_ra),
        .cache_out_instruction (c_rd)
    );

    uop_cache u_cache (
        .clk             (clk),
        .write_enable    (c_we),
        .write_address   (c_wa),
        .instruction     (c_wd),
        .read_enable     (c_re),
        .read_address    (c_ra),
        .out_instruction (c_rd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] uop_val(input int t, input int i);
        return 32'hC000_0000 | (t << 16) | i;
    endfunction

    // Monitor: every accepted output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_uop: got %0h with empty scoreboard", out_instr);
            end else begin
                chk("uop_order", out_instr, exp_q.pop_front());
            end
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic start(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [RW-1:0] r);
        cfg_start  = 1'b1;
        cfg_base   = b;
        cfg_len    = l;
        cfg_repeat = r;
        @(posedge clk); #1;
        cfg_start  = 1'b0;
    endtask

    task automatic fill(input int t, input logic [AW-1:0] b, input int l, input int r);
        logic [AW-1:0] a;
        for (int i = 0; i < l; i++) begin
            fill_valid = 1'b1;
            fill_instr = uop_val(t, i);
            a = b + AW'(i);
            @(negedge clk);
            chk("fill_ready", fill_ready, 1);
            chk("cache_we", c_we, 1);
            chk("cache_waddr", c_wa, a);
            @(posedge clk); #1;
        end
        fill_valid = 1'b0;
        fill_instr = '0;
        for (int p = 0; p <= r; p++)
            for (int i = 0; i < l; i++)
                exp_q.push_back(uop_val(t, i));
    endtask

    task automatic wait_done(input int limit, input bit rnd);
        bit seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (rnd) out_ready = ($urandom_range(0, 9) < 3);
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("busy_falls_with_done", busy, 0);
            @(posedge clk); #1;
            chk("done_one_cycle", done, 0);
        end
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fill_ready", fill_ready, 0);
        chk("rst_err", err, 0);
        chk("rst_cache_re", c_re, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Basic: latency and back-to-back output
        start(9'h010, 9'd4, 8'd0);
        fill(1, 9'h010, 4, 0);
        chk("lat_t0", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_t1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_t2", out_valid, 1);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            chk("basic_stream", out_valid, 1);
        end
        wait_done(20, 1'b0);

        // Address wrap with three passes
        start(9'h1FE, 9'd4, 8'd2);
        fill(2, 9'h1FE, 4, 2);
        @(posedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            chk("wrap_stream", out_valid, 1);
        end
        wait_done(20, 1'b0);

        // Random backpressure
        start(9'h040, 9'd8, 8'd0);
        fill(3, 9'h040, 8, 0);
        wait_done(2000, 1'b1);

        // Illegal length, then start while busy
        start(9'h000, 9'd0, 8'd0);
        chk("len0_err", err, 1);
        chk("len0_busy", busy, 0);
        start(9'h100, 9'd3, 8'd0);
        chk("err_cleared", err, 0);
        chk("busy_after_start", busy, 1);
        start(9'h055, 9'd7, 8'd5);
        chk("start_busy_err", err, 1);
        chk("start_busy_still_busy", busy, 1);
        fill(4, 9'h100, 3, 0);
        wait_done(50, 1'b0);
        chk("err_sticky", err, 1);

        // Abort after three outputs
        n_out = 0;
        start(9'h080, 9'd16, 8'd0);
        chk("err_cleared2", err, 0);
        fill(5, 9'h080, 16, 0);
        for (int k = 0; k < 100; k++) begin
            if (n_out == 3) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_outputs", n_out, 3);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        chk("abort_no_late_done", done, 0);
        chk("abort_out_valid2", out_valid, 0);
        exp_q.delete();
        out_ready = 1'b1;
        start(9'h000, 9'd5, 8'd1);
        fill(6, 9'h000, 5, 1);
        wait_done(50, 1'b0);

        // Asynchronous reset mid-replay
        start(9'h1F0, 9'd16, 8'd3);
        fill(7, 9'h1F0, 16, 3);
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cache_re", c_re, 0);
        chk("arst_raddr", c_ra, 0);
        chk("arst_out_instr", out_instr, 0);
        #14 reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk("arst_idle_busy", busy, 0);
        chk("arst_idle_valid", out_valid, 0);
        start(9'h020, 9'd2, 8'd0);
        fill(8, 9'h020, 2, 0);
        wait_done(30, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
